alu_cmd_ctrl: RTL
=================

# alu_cmd_ctrl

Command sequencer between the UART byte interface and `arithmetic_unit`. It assembles a framed command from received bytes: a header, operand A, then operand B. It drives the ALU for one operation, captures the result and status, and streams a response frame back toward UART TX under valid/ready flow control. It is the single owner of the ALU inputs and `enable` in the system.

## Interface
- `WIDTH`, 16, ALU operand/result width; must be a multiple of 8; NB = WIDTH/8 bytes per operand
- `TIMEOUT`, 4, maximum cycles in WAIT for `alu_flag` before the operation is aborted
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`
- `tx_data`  out  8  response byte
- `tx_valid`  out  1  response byte valid
- `tx_ready`  in  1  downstream accepts the byte on `tx_valid && tx_ready`
- `alu_a`, `alu_b`  out  WIDTH  ALU operands
- `alu_func`  out  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div
- `alu_enable`  out  1  ALU enable
- `alu_out`  in  WIDTH  ALU result (registered in the ALU)
- `alu_carry`  in  1  ALU carry out
- `alu_flag`  in  1  ALU result-valid flag
- `busy`  out  1  high whenever state ≠ IDLE
- `cmd_err`  out  1  one-cycle pulse on a rejected or dropped byte

## Operation
- States: IDLE, RX_A, RX_B, EXEC, WAIT, TX.
- **IDLE**
  - When `rx_valid` is high and `rx_data[7:2]` = 6'b101000 (header 0xA0|func), latch `alu_func` = `rx_data[1:0]`, clear the byte counter, and go to RX_A.
  - Any other byte: pulse `cmd_err` and stay in IDLE.
- **RX_A / RX_B**
  - Each `rx_valid` byte loads the next operand byte, LSB first.
  - After NB bytes, RX_A goes to RX_B and RX_B goes to EXEC.
  - There is no inter-byte timeout.
- **EXEC** (one cycle)
  - If `alu_func`=11 and `alu_b`=0: `alu_enable` stays 0, result=0, status div0=1, next state TX.
  - Otherwise: `alu_enable`=1 for exactly this cycle, next state WAIT.
- **WAIT**
  - On the first cycle with `alu_flag`=1, capture `alu_out` and `alu_carry`, then go to TX.
  - If `alu_flag` is not seen within TIMEOUT cycles: result=0, status timeout=1, go to TX.
- **TX**
  - Sends NB result bytes LSB first, then the status byte {5'b0, timeout, div0, carry}.
  - The byte index advances only on `tx_valid && tx_ready`.
  - After the status byte handshake, go to IDLE.
- **Byte arriving in EXEC, WAIT or TX:** the byte is dropped and `cmd_err` pulses; the current operation is unaffected.
- **Operand/func stability:** `alu_a`, `alu_b` and `alu_func` hold from EXEC until the next header is accepted.
- **carry for non-add operations:** carry is taken from the ALU as-is; the ALU drives 0 for sub, mul and div.

## Timing
- **Reset values:** state=IDLE; `tx_data`=0, `tx_valid`=0, `alu_a`=0, `alu_b`=0, `alu_func`=0, `alu_enable`=0, `busy`=0, `cmd_err`=0. Result and status registers are cleared.
- **Reset mid-frame or mid-TX:** the partial frame is discarded and `tx_valid` drops at the reset edge. The next header is accepted on the first cycle after `rst` deasserts.
- **Last B byte sampled at edge E0:**
  - `alu_enable` is high in cycle E0–E1.
  - The ALU asserts `alu_flag` after E1; the controller captures at E2.
  - `tx_valid` goes high after E2.
- **div0 path:** `tx_valid` goes high after E1.
- **Transmit rules:**
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - `tx_valid` is never deasserted without a handshake, except on reset.
- **Back-to-back frames:** `busy` falls the cycle after the status-byte handshake. A header on that same cycle is accepted.
- `cmd_err` is registered and pulses on the cycle after the offending byte.

## Test plan
- ADD: frame A0 FF FF 01 00 -> `alu_enable` pulses once; response 00 00 01 (0x0000, carry=1).
- SUB and MUL back-to-back: A1 34 12 34 00 -> 00 12 00; then A2 10 00 20 00 -> 00 02 00. The second header is accepted immediately after the first frame's status byte.
- DIV by zero: A3 64 00 00 00 -> `alu_enable` never asserts; response 00 00 02. Also A3 64 00 05 00 -> 14 00 00.
- Bad header and drop:
  - Byte 0x53 in IDLE -> `cmd_err` pulse, `busy` stays 0, no TX.
  - Byte sent during WAIT -> `cmd_err` pulse; the response is unchanged.
- Backpressure: hold `tx_ready`=0 for 5 cycles on each byte -> `tx_data` and `tx_valid` are held with no byte skipped or duplicated.
- Reset and timeout:
  - Assert `rst` after A0 FF FF -> all outputs return to reset values; a following full ADD frame responds correctly.
  - ALU model with `alu_flag` stuck at 0 -> after 4 WAIT cycles the response is 00 00 04.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: assembles header/operand frames from UART RX bytes, runs one
// ALU operation, and streams the result plus a status byte back under valid/ready.
module alu_cmd_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_func,
    output logic             alu_enable,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_flag,
    output logic             busy,
    output logic             cmd_err
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_A,
        S_RX_B,
        S_EXEC,
        S_WAIT,
        S_TX
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       func_q, func_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             div0_q, div0_d;
    logic             tmo_q, tmo_d;
    logic             cmd_err_q, cmd_err_d;
    logic             enable_c;
    logic [7:0]       tx_byte_c;
    logic             is_hdr_c;
    logic             div_zero_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            div0_q    <= 1'b0;
            tmo_q     <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            a_q       <= a_d;
            b_q       <= b_d;
            func_q    <= func_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            div0_q    <= div0_d;
            tmo_q     <= tmo_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        a_d        = a_q;
        b_d        = b_q;
        func_d     = func_q;
        res_d      = res_q;
        carry_d    = carry_q;
        div0_d     = div0_q;
        tmo_d      = tmo_q;
        cmd_err_d  = 1'b0;
        enable_c   = 1'b0;
        is_hdr_c   = (rx_data[7:2] == 6'b101000);
        div_zero_c = (func_q == 2'b11) && (b_q == '0);

        // Byte indices 0..NB-1 select result bytes; index NB is the status byte.
        tx_byte_c = {5'b0, tmo_q, div0_q, carry_q};
        for (int i = 0; i < NB; i++) begin
            if (cnt_q == IW'(i)) tx_byte_c = res_q[i*8 +: 8];
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (is_hdr_c) begin
                        func_d  = rx_data[1:0];
                        cnt_d   = '0;
                        state_d = S_RX_A;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_RX_A: begin
                if (rx_valid) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == IW'(i)) a_d[i*8 +: 8] = rx_data;
                    end
                    if (cnt_q == IW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = S_RX_B;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            S_RX_B: begin
                if (rx_valid) begin
                    for (int i = 0; i < NB; i++) begin
                        if (cnt_q == IW'(i)) b_d[i*8 +: 8] = rx_data;
                    end
                    if (cnt_q == IW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            S_EXEC: begin
                cmd_err_d = rx_valid;
                cnt_d     = '0;
                wait_d    = '0;
                if (div_zero_c) begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    div0_d  = 1'b1;
                    tmo_d   = 1'b0;
                    state_d = S_TX;
                end else begin
                    enable_c = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                cmd_err_d = rx_valid;
                if (alu_flag) begin
                    res_d   = alu_out;
                    carry_d = alu_carry;
                    div0_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = S_TX;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    div0_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_TX;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_TX: begin
                cmd_err_d = rx_valid;
                if (tx_ready) begin
                    if (cnt_q == IW'(NB)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_valid   = (state_q == S_TX);
    assign tx_data    = tx_valid ? tx_byte_c : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign alu_enable = enable_c;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_func   = func_q;
    assign cmd_err    = cmd_err_q;

endmodule
